// File: rtl/matmul_tile_ctrl.sv
// matmul_tile_ctrl: loads NxN A and B matrices from a stream, computes C = A x B through one shared 2x2 block multiplier, and streams C out row-major.
// Latency: first out_valid (N/2)^3*(MM_LATENCY+1)+1 cycles after the last input handshake.
// Backpressure: in_ready is high only in IDLE/LOAD; out_data is held while out_ready=0. The MATMUL_TILE_CTRL_SAT_EN macro enables saturating accumulation and adds the sat_flag port.
`timescale 1ns/1ps
module matmul_tile_ctrl #(
    parameter int N          = 4,
    parameter int MM_LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic [63:0]  mm_a,
    output logic [63:0]  mm_b,
    input  logic [127:0] mm_c,
`ifdef MATMUL_TILE_CTRL_SAT_EN
    output logic         sat_flag,
`endif
    output logic         busy,
    output logic         done
);

    localparam int NN = N * N;
    localparam int HN = N / 2;
    localparam int AW = $clog2(NN);
    localparam int LW = $clog2(2 * NN);
    localparam int TW = (HN > 1) ? $clog2(HN) : 1;
    localparam int WW = (MM_LATENCY > 1) ? $clog2(MM_LATENCY) : 1;

    localparam logic [TW-1:0] T_LAST  = TW'(HN - 1);
    localparam logic [WW-1:0] W_LAST  = WW'(MM_LATENCY - 1);
    localparam logic [LW-1:0] LD_LAST = LW'(2 * NN - 1);
    localparam logic [LW-1:0] LD_B    = LW'(NN);
    localparam logic [AW-1:0] C_LAST  = AW'(NN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [LW-1:0] ld_cnt_q;
    logic [TW-1:0] ti_q, tj_q, tk_q;
    logic [WW-1:0] wt_cnt_q;
    logic [AW-1:0] oidx_q;
    logic [AW-1:0] oidx_nxt;

    logic [15:0] a_mem [NN];
    logic [15:0] b_mem [NN];
    logic [31:0] c_mem [NN];

    logic [31:0] acc_q   [4];
    logic [31:0] acc_sum [4];

    logic        in_ready_q, in_ready_d;
    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic [63:0] mm_a_q, mm_b_q;
    logic        done_q;

    logic in_hs, out_hs;
    logic wait_last, k_last, j_last, i_last, all_last;

    int row_i, col_j, dep_k;

    // Flat row-major index of element (r, c) in an NxN buffer.
    function automatic logic [AW-1:0] idx(input int r, input int c);
        return AW'(r * N + c);
    endfunction

    assign row_i    = 2 * int'(ti_q);
    assign col_j    = 2 * int'(tj_q);
    assign dep_k    = 2 * int'(tk_q);
    assign oidx_nxt = oidx_q + AW'(1);

    assign in_hs     = in_valid & in_ready_q;
    assign out_hs    = out_valid_q & out_ready;
    assign k_last    = (tk_q == T_LAST);
    assign j_last    = (tj_q == T_LAST);
    assign i_last    = (ti_q == T_LAST);
    assign all_last  = k_last & j_last & i_last;
    assign wait_last = (state_q == S_WAIT) && (wt_cnt_q == W_LAST);

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign mm_a      = mm_a_q;
    assign mm_b      = mm_b_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);

`ifdef MATMUL_TILE_CTRL_SAT_EN
    logic        sat_q;
    logic        sat_hit;
    logic [32:0] sum33;

    assign sat_flag = sat_q;

    // Per-lane accumulate with clamp at all-ones; sat_hit flags any clamped lane.
    always_comb begin
        sat_hit = 1'b0;
        sum33   = '0;
        for (int l = 0; l < 4; l++) begin
            sum33 = {1'b0, acc_q[l]} + {1'b0, mm_c[32*l +: 32]};
            if (sum33[32]) begin
                acc_sum[l] = 32'hFFFF_FFFF;
                sat_hit    = 1'b1;
            end else begin
                acc_sum[l] = sum33[31:0];
            end
        end
    end

    // Sticky saturation flag, cleared when a new job's first element arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (in_hs && state_q == S_IDLE) begin
            sat_q <= 1'b0;
        end else if (wait_last && sat_hit) begin
            sat_q <= 1'b1;
        end
    end
`else
    // Per-lane accumulate, wrapping modulo 2^32.
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            acc_sum[l] = acc_q[l] + mm_c[32*l +: 32];
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in_ready is registered from the next state so it is low during reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_hs) state_d = S_LOAD;
            S_LOAD:  if (in_hs && ld_cnt_q == LD_LAST) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (wait_last) state_d = all_last ? S_DRAIN : S_ISSUE;
            S_DRAIN: if (out_hs && oidx_q == C_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    end

    // Load counter, tile loop counters and the multiplier wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q <= 1'b0;
            ld_cnt_q   <= '0;
            ti_q       <= '0;
            tj_q       <= '0;
            tk_q       <= '0;
            wt_cnt_q   <= '0;
        end else begin
            in_ready_q <= in_ready_d;
            if (in_hs) begin
                ld_cnt_q <= (ld_cnt_q == LD_LAST) ? '0 : ld_cnt_q + LW'(1);
            end
            if (state_q == S_WAIT) begin
                wt_cnt_q <= wait_last ? '0 : wt_cnt_q + WW'(1);
            end else begin
                wt_cnt_q <= '0;
            end
            if (wait_last) begin
                if (k_last) begin
                    tk_q <= '0;
                    if (j_last) begin
                        tj_q <= '0;
                        ti_q <= i_last ? '0 : ti_q + TW'(1);
                    end else begin
                        tj_q <= tj_q + TW'(1);
                    end
                end else begin
                    tk_q <= tk_q + TW'(1);
                end
            end
        end
    end

    // Operand and result buffers: A then B fill from the stream, C tiles land after the last k block.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            if (ld_cnt_q < LD_B) begin
                a_mem[AW'(ld_cnt_q)] <= in_data;
            end else begin
                b_mem[AW'(ld_cnt_q - LD_B)] <= in_data;
            end
        end
        if (wait_last && k_last) begin
            c_mem[idx(row_i,     col_j    )] <= acc_sum[0];
            c_mem[idx(row_i,     col_j + 1)] <= acc_sum[1];
            c_mem[idx(row_i + 1, col_j    )] <= acc_sum[2];
            c_mem[idx(row_i + 1, col_j + 1)] <= acc_sum[3];
        end
    end

    // Multiplier operand tiles and the partial-sum accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_a_q <= '0;
            mm_b_q <= '0;
            for (int l = 0; l < 4; l++) acc_q[l] <= '0;
        end else begin
            if (state_q == S_ISSUE) begin
                mm_a_q <= {a_mem[idx(row_i + 1, dep_k + 1)], a_mem[idx(row_i + 1, dep_k)],
                           a_mem[idx(row_i,     dep_k + 1)], a_mem[idx(row_i,     dep_k)]};
                mm_b_q <= {b_mem[idx(dep_k + 1, col_j + 1)], b_mem[idx(dep_k + 1, col_j)],
                           b_mem[idx(dep_k,     col_j + 1)], b_mem[idx(dep_k,     col_j)]};
                if (tk_q == '0) begin
                    for (int l = 0; l < 4; l++) acc_q[l] <= '0;
                end
            end else if (wait_last) begin
                for (int l = 0; l < 4; l++) acc_q[l] <= acc_sum[l];
            end
        end
    end

    // Output streamer: the first DRAIN cycle presents C[0], then one element per handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            oidx_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == S_DRAIN) begin
                if (!out_valid_q) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= c_mem[oidx_q];
                end else if (out_hs) begin
                    if (oidx_q == C_LAST) begin
                        out_valid_q <= 1'b0;
                        oidx_q      <= '0;
                        done_q      <= 1'b1;
                    end else begin
                        oidx_q     <= oidx_nxt;
                        out_data_q <= c_mem[oidx_nxt];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_matmul_tile_ctrl.sv
// Bench for matmul_tile_ctrl: N=4 and N=2 instances, each with a behavioural 2x2 multiplier.
// Expected C comes from a plain matrix-product model; one compare process checks every output cycle.
// Directed jobs cover identity, 2x2, overflow, drain stalls, input gaps and mid-job reset.
`timescale 1ns/1ps
module tb_matmul_tile_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [15:0]  in_data   [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [31:0]  out_data  [2];
    logic [63:0]  mm_a      [2];
    logic [63:0]  mm_b      [2];
    logic [127:0] mm_c      [2];
    logic         busy      [2];
    logic         done      [2];
`ifdef MATMUL_TILE_CTRL_SAT_EN
    logic         sat_flag  [2];
`endif

    matmul_tile_ctrl #(.N(4), .MM_LATENCY(2)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .mm_a(mm_a[0]), .mm_b(mm_b[0]), .mm_c(mm_c[0]),
`ifdef MATMUL_TILE_CTRL_SAT_EN
        .sat_flag(sat_flag[0]),
`endif
        .busy(busy[0]), .done(done[0])
    );

    matmul_tile_ctrl #(.N(2), .MM_LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .mm_a(mm_a[1]), .mm_b(mm_b[1]), .mm_c(mm_c[1]),
`ifdef MATMUL_TILE_CTRL_SAT_EN
        .sat_flag(sat_flag[1]),
`endif
        .busy(busy[1]), .done(done[1])
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [15:0] A [16];
    logic [15:0] B [16];
    logic [31:0] exp_q [2][$];
    logic [31:0] s2_ref [4] = '{32'd19, 32'd22, 32'd43, 32'd50};
    bit          done_due   [2];
    bit          first_seen [2];
    int          first_cyc  [2];
    int          last_in_cyc[2];
    int          hs_cnt     [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // External 2x2 multiplier: 32-bit lanes, result registered once after the operands.
    function automatic logic [127:0] blk(input logic [63:0] a, input logic [63:0] b);
        logic [31:0] c00, c01, c10, c11;
        c00 = 32'(a[15:0])  * 32'(b[15:0])  + 32'(a[31:16]) * 32'(b[47:32]);
        c01 = 32'(a[15:0])  * 32'(b[31:16]) + 32'(a[31:16]) * 32'(b[63:48]);
        c10 = 32'(a[47:32]) * 32'(b[15:0])  + 32'(a[63:48]) * 32'(b[47:32]);
        c11 = 32'(a[47:32]) * 32'(b[31:16]) + 32'(a[63:48]) * 32'(b[63:48]);
        return {c11, c10, c01, c00};
    endfunction

    always @(posedge clk) begin
        mm_c[0] <= blk(mm_a[0], mm_b[0]);
        mm_c[1] <= blk(mm_a[1], mm_b[1]);
    end

    // Reference C = A x B (row-major), queued in output order.
    task automatic build_exp(input int d, input int n);
        logic [31:0] acc;
`ifdef MATMUL_TILE_CTRL_SAT_EN
        logic [31:0] pair;
        logic [32:0] s;
`endif
        exp_q[d].delete();
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                acc = '0;
`ifdef MATMUL_TILE_CTRL_SAT_EN
                for (int k = 0; k < n; k += 2) begin
                    pair = 32'(A[i*n+k]) * 32'(B[k*n+j]) + 32'(A[i*n+k+1]) * 32'(B[(k+1)*n+j]);
                    s    = {1'b0, acc} + {1'b0, pair};
                    acc  = s[32] ? 32'hFFFF_FFFF : s[31:0];
                end
`else
                for (int k = 0; k < n; k++) acc = acc + 32'(A[i*n+k]) * 32'(B[k*n+j]);
`endif
                exp_q[d].push_back(acc);
            end
        end
        first_seen[d] = 1'b0;
        hs_cnt[d]     = 0;
        done_due[d]   = 1'b0;
    endtask

    // Compare process: done pulse timing, out_data against the model, handshake accounting.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("done%0d", d), 128'(done[d]), 128'(done_due[d]));
                done_due[d] = 1'b0;
                if (out_valid[d]) begin
                    if (!first_seen[d]) begin
                        first_seen[d] = 1'b1;
                        first_cyc[d]  = cyc;
                    end
                    if (exp_q[d].size() == 0) begin
                        chk($sformatf("extra_out%0d", d), 128'(out_valid[d]), 128'(0));
                    end else begin
                        chk($sformatf("out_data%0d_idx%0d", d, hs_cnt[d]),
                            128'(out_data[d]), 128'(exp_q[d][0]));
                        if (out_ready[d]) begin
                            void'(exp_q[d].pop_front());
                            hs_cnt[d]++;
                            if (exp_q[d].size() == 0) done_due[d] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic load_job(input int d, input int n, input int gap_at);
        bit ok;
        int t;
        for (int k = 0; k < 2*n*n; k++) begin
            if (k == gap_at) begin
                in_valid[d] = 1'b0;
                in_data[d]  = 16'hBEEF;
                repeat (3) @(posedge clk);
                #1;
            end
            in_valid[d] = 1'b1;
            in_data[d]  = (k < n*n) ? A[k] : B[k - n*n];
            ok = 1'b0;
            t  = 0;
            while (!ok && t < 50) begin
                @(negedge clk);
                ok = in_ready[d];
                @(posedge clk);
                #1;
                t++;
            end
            chk($sformatf("in_accept%0d_k%0d", d, k), 128'(ok), 128'(1));
        end
        in_valid[d]    = 1'b0;
        in_data[d]     = 16'hDEAD;
        last_in_cyc[d] = cyc;
    endtask

    task automatic drain(input int d, input int n, input bit bp, input int lat, input string tag);
        int t;
        t = 0;
        while ((exp_q[d].size() != 0 || done_due[d]) && t < 3000) begin
            out_ready[d] = bp ? (t % 3 == 0) : 1'b1;
            @(posedge clk);
            #1;
            t++;
        end
        out_ready[d] = 1'b1;
        chk({tag, "_remaining"}, 128'(exp_q[d].size()), 128'(0));
        chk({tag, "_latency"}, 128'(first_cyc[d] - last_in_cyc[d]), 128'(lat));
        chk({tag, "_handshakes"}, 128'(hs_cnt[d]), 128'(n*n));
    endtask

    task automatic check_reset(input int d);
        chk($sformatf("rst_in_ready%0d", d),  128'(in_ready[d]),  128'(0));
        chk($sformatf("rst_out_valid%0d", d), 128'(out_valid[d]), 128'(0));
        chk($sformatf("rst_out_data%0d", d),  128'(out_data[d]),  128'(0));
        chk($sformatf("rst_mm_a%0d", d),      128'(mm_a[d]),      128'(0));
        chk($sformatf("rst_mm_b%0d", d),      128'(mm_b[d]),      128'(0));
        chk($sformatf("rst_busy%0d", d),      128'(busy[d]),      128'(0));
        chk($sformatf("rst_done%0d", d),      128'(done[d]),      128'(0));
    endtask

    task automatic set_ident_seq();
        for (int i = 0; i < 16; i++) begin
            A[i] = (i / 4 == i % 4) ? 16'd1 : 16'd0;
            B[i] = 16'(i + 1);
        end
    endtask

    task automatic set_2x2();
        for (int i = 0; i < 4; i++) begin
            A[i] = 16'(i + 1);
            B[i] = 16'(i + 5);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            out_ready[d] = 1'b1;
            done_due[d]  = 1'b0;
        end
        #1 rst = 1'b1;
        #10;
        check_reset(0);
        check_reset(1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Identity times 1..16.
        set_ident_seq();
        build_exp(0, 4);
        for (int i = 0; i < 16; i++) chk($sformatf("model_s1_%0d", i), 128'(exp_q[0][i]), 128'(i + 1));
        load_job(0, 4, -1);
        drain(0, 4, 1'b0, 25, "s1");

        // 2x2 product on the N=2 instance.
        set_2x2();
        build_exp(1, 2);
        for (int i = 0; i < 4; i++) chk($sformatf("model_s2_%0d", i), 128'(exp_q[1][i]), 128'(s2_ref[i]));
        load_job(1, 2, -1);
        drain(1, 2, 1'b0, 4, "s2");

        // All-ones operands: accumulator overflow.
        for (int i = 0; i < 16; i++) begin
            A[i] = 16'hFFFF;
            B[i] = 16'hFFFF;
        end
        build_exp(0, 4);
`ifdef MATMUL_TILE_CTRL_SAT_EN
        chk("model_s3", 128'(exp_q[0][5]), 128'(32'hFFFF_FFFF));
`else
        chk("model_s3", 128'(exp_q[0][5]), 128'(32'hFFF8_0004));
`endif
        load_job(0, 4, -1);
        drain(0, 4, 1'b0, 25, "s3");
`ifdef MATMUL_TILE_CTRL_SAT_EN
        chk("s3_sat_flag", 128'(sat_flag[0]), 128'(1));
`endif

        // Drain backpressure with out_ready 1,0,0 repeating.
        set_ident_seq();
        build_exp(0, 4);
        load_job(0, 4, -1);
        drain(0, 4, 1'b1, 25, "s4");

        // Three-cycle in_valid gap in the middle of B.
        build_exp(0, 4);
        load_job(0, 4, 24);
        drain(0, 4, 1'b0, 25, "s5");

        // Reset while waiting on the multiplier, then a clean 2x2 job.
        set_2x2();
        build_exp(1, 2);
        load_job(1, 2, -1);
        @(posedge clk); #1;
        chk("s6_mm_a", 128'(mm_a[1]), 128'(64'h0004_0003_0002_0001));
        chk("s6_mm_b", 128'(mm_b[1]), 128'(64'h0008_0007_0006_0005));
        chk("s6_busy", 128'(busy[1]), 128'(1));
        rst = 1'b1;
        #1;
        check_reset(1);
        exp_q[1].delete();
        done_due[1] = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        build_exp(1, 2);
        load_job(1, 2, -1);
        drain(1, 2, 1'b0, 4, "s6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
